// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the sizing helper for its bit counter.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // The counter must reach WIDTH after the last bit, so it needs clog2(WIDTH+1) bits.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full-subtractor cell, gate-level, the borrow-side counterpart of
// the full_adder cell.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic z,
    output logic diff,
    output logic bout
);

    assign diff = x ^ y ^ z;
    assign bout = (~x & y) | (~(x ^ y) & z);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: d = a - b - bin, LSB first, one bit per clock through
// a single full_subtractor cell, with start/busy/done handshake.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bout
);

    localparam int               CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             borrow_q, borrow_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             bout_q, bout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             cell_diff_s;
    logic             cell_borrow_s;
    logic [WIDTH-1:0] res_shift_s;

    full_subtractor u_cell (
        .x    (a_q[0]),
        .y    (b_q[0]),
        .z    (borrow_q),
        .diff (cell_diff_s),
        .bout (cell_borrow_s)
    );

    // Next-state, datapath and handshake computation.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        res_d       = res_q;
        borrow_d    = borrow_q;
        cnt_d       = cnt_q;
        d_d         = d_q;
        bout_d      = bout_q;
        // New difference bit enters from the MSB so bit 0 lands at the LSB after WIDTH shifts.
        res_shift_s              = res_q >> 1'b1;
        res_shift_s[WIDTH-1]     = cell_diff_s;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d      = a;
                    b_d      = b;
                    borrow_d = bin;
                    cnt_d    = {CNT_W{1'b0}};
                    state_d  = ST_RUN;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_RUN: begin
                a_d      = a_q >> 1'b1;
                b_d      = b_q >> 1'b1;
                res_d    = res_shift_s;
                borrow_d = cell_borrow_s;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
                    d_d     = res_shift_s;
                    bout_d  = cell_borrow_s;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    // State, operand, result and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            a_q      <= {WIDTH{1'b0}};
            b_q      <= {WIDTH{1'b0}};
            res_q    <= {WIDTH{1'b0}};
            borrow_q <= 1'b0;
            cnt_q    <= {CNT_W{1'b0}};
            d_q      <= {WIDTH{1'b0}};
            bout_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_d;
            d_q      <= d_d;
            bout_q   <= bout_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign d    = d_q;
    assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor at WIDTH=4 (directed + exhaustive),
// WIDTH=1 (exhaustive) and WIDTH=8 (spot checks).
module tb_serial_subtractor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic       start4, bin4, busy4, done4, bout4;
    logic [3:0] a4, b4, d4;
    logic       start1, bin1, busy1, done1, bout1;
    logic [0:0] a1, b1, d1;
    logic       start8, bin8, busy8, done8, bout8;
    logic [7:0] a8, b8, d8;

    serial_subtractor #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .bin(bin4),
        .busy(busy4), .done(done4), .d(d4), .bout(bout4)
    );
    serial_subtractor #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .bin(bin1),
        .busy(busy1), .done(done1), .d(d1), .bout(bout1)
    );
    serial_subtractor #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .bin(bin8),
        .busy(busy8), .done(done8), .d(d8), .bout(bout8)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [63:0] exp4_q[$];
    logic [63:0] exp1_q[$];
    logic [63:0] exp8_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: {bout, d} with bout placed at bit w.
    function automatic logic [63:0] model(input int w, input longint ua, input longint ub,
                                          input longint ubin);
        longint      diff;
        logic [63:0] mask;
        diff = ua - ub - ubin;
        mask = (64'd1 << w) - 64'd1;
        return ((ua < ub + ubin) ? (64'd1 << w) : 64'd0) | (64'(diff) & mask);
    endfunction

    always @(negedge clk) begin
        if (rst_n && done4) begin
            if (exp4_q.size() == 0) check("w4_unexpected_done", 64'd1, 64'd0);
            else check("w4_result", {59'd0, bout4, d4}, exp4_q.pop_front());
        end
        if (rst_n && done1) begin
            if (exp1_q.size() == 0) check("w1_unexpected_done", 64'd1, 64'd0);
            else check("w1_result", {62'd0, bout1, d1}, exp1_q.pop_front());
        end
        if (rst_n && done8) begin
            if (exp8_q.size() == 0) check("w8_unexpected_done", 64'd1, 64'd0);
            else check("w8_result", {55'd0, bout8, d8}, exp8_q.pop_front());
        end
    end

    task automatic op4(input logic [3:0] ta, input logic [3:0] tb, input logic tbin);
        logic [3:0] prev_d;
        logic       held;
        int         lat, busy_n;
        @(posedge clk); #1;
        a4 = ta; b4 = tb; bin4 = tbin; start4 = 1'b1;
        exp4_q.push_back(model(4, ta, tb, tbin));
        prev_d = d4;
        @(posedge clk); #1;
        start4 = 1'b0;
        held = 1'b1; lat = 0; busy_n = 0;
        while (!done4 && lat < 20) begin
            @(negedge clk);
            if (!done4) begin
                lat++;
                if (busy4) busy_n++;
                if (d4 !== prev_d) held = 1'b0;
            end
        end
        check("w4_latency", lat, 4);
        check("w4_busy_cycles", busy_n, 4);
        check("w4_d_held_in_run", held, 1'b1);
    endtask

    task automatic op1(input logic ta, input logic tb, input logic tbin);
        int lat;
        @(posedge clk); #1;
        a1 = ta; b1 = tb; bin1 = tbin; start1 = 1'b1;
        exp1_q.push_back(model(1, ta, tb, tbin));
        @(posedge clk); #1;
        start1 = 1'b0;
        lat = 0;
        while (!done1 && lat < 10) begin
            @(negedge clk);
            if (!done1) lat++;
        end
        check("w1_latency", lat, 1);
    endtask

    task automatic op8(input logic [7:0] ta, input logic [7:0] tb, input logic tbin);
        int lat;
        @(posedge clk); #1;
        a8 = ta; b8 = tb; bin8 = tbin; start8 = 1'b1;
        exp8_q.push_back(model(8, ta, tb, tbin));
        @(posedge clk); #1;
        start8 = 1'b0;
        lat = 0;
        while (!done8 && lat < 30) begin
            @(negedge clk);
            if (!done8) lat++;
        end
        check("w8_latency", lat, 8);
    endtask

    initial begin
        int nd;
        rst_n = 1'b0;
        start4 = 1'b0; a4 = 4'd0; b4 = 4'd0; bin4 = 1'b0;
        start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; bin1 = 1'b0;
        start8 = 1'b0; a8 = 8'd0; b8 = 8'd0; bin8 = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("reset_busy", busy4, 1'b0);
        check("reset_done", done4, 1'b0);
        check("reset_d", d4, 4'd0);
        check("reset_bout", bout4, 1'b0);

        // Directed cases
        op4(4'd9, 4'd5, 1'b0);
        check("t1_d", d4, 4'd4);
        check("t1_bout", bout4, 1'b0);
        op4(4'd3, 4'd5, 1'b0);
        check("t2_d", d4, 4'hE);
        check("t2_bout", bout4, 1'b1);
        op4(4'd0, 4'd0, 1'b1);
        check("t3_d", d4, 4'hF);
        check("t3_bout", bout4, 1'b1);

        // start held high; operands change mid-RUN
        @(posedge clk); #1;
        a4 = 4'd7; b4 = 4'd7; bin4 = 1'b0; start4 = 1'b1;
        exp4_q.push_back(model(4, 7, 7, 0));
        @(posedge clk); #1;
        a4 = 4'd1; b4 = 4'd2;
        exp4_q.push_back(model(4, 1, 2, 0));
        nd = 0;
        for (int i = 0; i <= 12; i++) begin
            @(negedge clk);
            if (i == 7) start4 = 1'b0;
            if (done4) begin
                check("t4_done_edge", i, (nd == 0) ? 4 : 10);
                nd++;
            end
        end
        check("t4_done_count", nd, 2);
        check("t4_queue_drained", exp4_q.size(), 0);

        // Reset after two RUN edges aborts the operation
        @(posedge clk); #1;
        a4 = 4'd9; b4 = 4'd5; bin4 = 1'b0; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("t5_busy", busy4, 1'b0);
        check("t5_done", done4, 1'b0);
        check("t5_d", d4, 4'd0);
        check("t5_bout", bout4, 1'b0);
        op4(4'd15, 4'd1, 1'b0);
        check("t5_d_after", d4, 4'd14);
        check("t5_bout_after", bout4, 1'b0);

        // Exhaustive WIDTH=4 sweep
        for (int ia = 0; ia < 16; ia++)
            for (int ib = 0; ib < 16; ib++)
                for (int ic = 0; ic < 2; ic++)
                    op4(4'(ia), 4'(ib), 1'(ic));

        // WIDTH=1 exhaustive and WIDTH=8 spot checks
        for (int k = 0; k < 8; k++)
            op1(1'(k >> 2), 1'(k >> 1), 1'(k));
        op8(8'h00, 8'h01, 1'b0);
        check("w8_d_wrap", d8, 8'hFF);
        check("w8_bout_wrap", bout8, 1'b1);
        op8(8'd200, 8'd55, 1'b1);
        op8(8'hFF, 8'hFF, 1'b1);
        for (int k = 0; k < 10; k++)
            op8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));

        repeat (4) @(negedge clk);
        check("w4_queue_empty", exp4_q.size(), 0);
        check("w1_queue_empty", exp1_q.size(), 0);
        check("w8_queue_empty", exp8_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial borrow-ripple subtractor, the inverse operation to the team's combinational ripple adder. It computes d = a - b - bin, LSB first, one bit per clock, through a single full-subtractor cell and a registered borrow. Start/busy/done handshake; a finished result is held until the next result completes. Used where area matters more than latency, e.g. counters and comparators in slow control paths.

Parameters:
WIDTH, 4, operand and result width in bits (>= 1)

Ports:
clk    input   1      rising-edge clock
rst_n  input   1      reset; synchronous, active-low
start  input   1      request; sampled only in IDLE
a      input   WIDTH  minuend; captured when start is accepted
b      input   WIDTH  subtrahend; captured when start is accepted
bin    input   1      borrow-in; captured when start is accepted
busy   output  1      high while in RUN
done   output  1      one-cycle pulse: d/bout just updated
d      output  WIDTH  difference, registered
bout   output  1      borrow-out, registered

Behaviour:
- Reset: rst_n low at a rising edge forces the following, with no partial result kept:
  - state IDLE
  - busy=0, done=0, d=0, bout=0
  - internal operand/shift registers, borrow flop and bit counter = 0
- Reset mid-RUN or mid-DONE aborts the operation. Reset wins over start on the same edge.
- Arithmetic (unsigned):
  - d = (a - b - bin) mod 2^WIDTH
  - bout = 1 iff a < b + bin
- Full-subtractor cell, for bit x = a[i], y = b[i], z = current borrow:
  - diff = x^y^z
  - borrow_next = (~x & y) | (~(x^y) & z)
- States:
  - IDLE: busy=0. Edge with start=1 → latch a, b into shift registers, borrow ← bin, cnt ← 0, go to RUN.
  - RUN: busy=1. Each edge:
    - compute bit cnt from the operand LSBs
    - shift the diff bit into the result shift register from the MSB side
    - shift the operands right, update borrow, cnt ← cnt+1
    - on the edge processing bit WIDTH-1: copy the full result to d and the final borrow to bout, set done=1, go to DONE
  - DONE: done=1 for exactly this cycle, busy=0. Next edge → IDLE, done=0.
- Latency and throughput:
  - start sampled at edge 0 → done high after edge WIDTH, for one cycle.
  - New operation every WIDTH+2 cycles maximum.
- start is ignored in RUN and DONE; it is never queued. Holding start high gives back-to-back operations, each re-sampling a/b/bin in IDLE.
- a/b/bin may change freely after acceptance without affecting the result in flight.
- d/bout keep the previous result throughout RUN. They change only on the completing edge or on reset.
- WIDTH=1: RUN lasts one edge; same rules apply.
- Counter width is clog2(WIDTH+1). No wrap occurs inside an operation.

Decomposition:
- Shared package holds:
  - state encoding: IDLE=2'b00, RUN=2'b01, DONE=2'b10
  - a function for the counter width
- One sub-module, full_subtractor (x, y, z → diff, bout), gate-level. It mirrors the full_adder cell style and is instantiated once.

Test Plan:
1. WIDTH=4, a=9, b=5, bin=0, start pulse → busy for 4 cycles; done after edge 4; d=4, bout=0.
2. a=3, b=5, bin=0 → d=4'hE, bout=1. Previous d=4 stays visible during RUN until the completing edge.
3. a=0, b=0, bin=1 (borrow ripples through all bits) → d=4'hF, bout=1.
4. start held high continuously with a=7, b=7, bin=0, operands changed to a=1, b=2 during RUN:
   - first result d=0, bout=0
   - IDLE gap, second result d=4'hF, bout=1
   - exactly one done per operation
5. rst_n low after 2 RUN edges → next cycle busy=0, done=0, d=0, bout=0. Then a=15, b=1, bin=0 → d=14, bout=0, with full 4-cycle latency.
6. Exhaustive WIDTH=4 sweep (all a, b, bin = 512 cases) against a behavioural model. Then WIDTH=1 and WIDTH=8 spot checks: 8'h00-8'h01 → 8'hFF, bout=1.
